// File: rtl/tns_decoder_15_pipe_pkg.sv
// Shared TNS constants: group layout, data width and the Fibonacci bit weights
// that the 15-bit encoder uses (bit 0 carries the unit weight).
package tns_decoder_15_pipe_pkg;

    localparam int BLEN05         = 11;
    localparam int TNS_DEC_STAGES = 5;
    localparam int TNS_GROUP_W    = 3;
    localparam int TNS_CODE_W     = TNS_DEC_STAGES * TNS_GROUP_W;

    typedef logic [BLEN05-1:0] tns_word_t;

    localparam tns_word_t TNS05_A = 11'd987;
    localparam tns_word_t TNS05_B = 11'd610;
    localparam tns_word_t TNS05_C = 11'd377;
    localparam tns_word_t TNS04_A = 11'd233;
    localparam tns_word_t TNS04_B = 11'd144;
    localparam tns_word_t TNS04_C = 11'd89;
    localparam tns_word_t TNS03_A = 11'd55;
    localparam tns_word_t TNS03_B = 11'd34;
    localparam tns_word_t TNS03_C = 11'd21;
    localparam tns_word_t TNS02_A = 11'd13;
    localparam tns_word_t TNS02_B = 11'd8;
    localparam tns_word_t TNS02_C = 11'd5;
    localparam tns_word_t TNS01_A = 11'd3;
    localparam tns_word_t TNS01_B = 11'd2;
    localparam tns_word_t TNS01_C = 11'd1;

endpackage

// File: rtl/tns_decoder_15_pipe_group_stage.sv
// One decoder pipeline stage: adds the weighted value of one 3-bit group to the
// running sum and holds it while the stage downstream is stalled.
module tns_dec_group_stage
    import tns_decoder_15_pipe_pkg::*;
#(
    parameter int            DW  = BLEN05,
    parameter logic [DW-1:0] W_A = '0,
    parameter logic [DW-1:0] W_B = '0,
    parameter logic [DW-1:0] W_C = '0
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [2:0]    grp_i,
    input  logic [DW-1:0] acc_i,
    input  logic          v_i,
    input  logic          adv_next_i,
    output logic          adv_o,
    output logic          v_o,
    output logic [DW-1:0] acc_o
);

    logic          v_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;

    assign adv_o = ~v_q | adv_next_i;

    // Sum wraps modulo 2^DW; illegal codewords decode without any flag.
    always_comb begin
        acc_d = acc_i
              + (grp_i[2] ? W_A : '0)
              + (grp_i[1] ? W_B : '0)
              + (grp_i[0] ? W_C : '0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            v_q   <= 1'b0;
            acc_q <= '0;
        end else if (adv_o) begin
            v_q <= v_i;
            if (v_i) begin
                acc_q <= acc_d;
            end
        end
    end

    assign v_o   = v_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/tns_decoder_15_pipe.sv
// Five-stage TNS codeword decoder, one 3-bit group per stage from the MSB group
// down, with a combinational ready chain that compresses bubbles.
module tns_decoder_15_pipe
    import tns_decoder_15_pipe_pkg::*;
#(
    parameter int GROUPS = 5,
    parameter int DW     = BLEN05
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [TNS_CODE_W-1:0] code_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW-1:0]         data_out,
    output logic                  out_valid,
    input  logic                  out_ready
);

    if (GROUPS != TNS_DEC_STAGES) begin : g_bad_groups
        $error("tns_decoder_15_pipe: GROUPS must be 5");
    end
    if (DW != BLEN05) begin : g_bad_dw
        $error("tns_decoder_15_pipe: DW must equal BLEN05");
    end

    logic          v   [1:5];
    logic          adv [1:5];
    logic [DW-1:0] acc [1:5];

    // Undecoded low codeword bits travelling alongside each stage's partial sum.
    logic [11:0] rem1_q;
    logic [8:0]  rem2_q;
    logic [5:0]  rem3_q;
    logic [2:0]  rem4_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            rem1_q <= '0;
            rem2_q <= '0;
            rem3_q <= '0;
            rem4_q <= '0;
        end else begin
            if (adv[1] && in_valid) rem1_q <= code_in[11:0];
            if (adv[2] && v[1])     rem2_q <= rem1_q[8:0];
            if (adv[3] && v[2])     rem3_q <= rem2_q[5:0];
            if (adv[4] && v[3])     rem4_q <= rem3_q[2:0];
        end
    end

    tns_dec_group_stage #(.DW(DW), .W_A(TNS05_A), .W_B(TNS05_B), .W_C(TNS05_C)) u_stage1 (
        .clock      (clock),
        .rst        (rst),
        .grp_i      (code_in[14:12]),
        .acc_i      ('0),
        .v_i        (in_valid),
        .adv_next_i (adv[2]),
        .adv_o      (adv[1]),
        .v_o        (v[1]),
        .acc_o      (acc[1])
    );

    tns_dec_group_stage #(.DW(DW), .W_A(TNS04_A), .W_B(TNS04_B), .W_C(TNS04_C)) u_stage2 (
        .clock      (clock),
        .rst        (rst),
        .grp_i      (rem1_q[11:9]),
        .acc_i      (acc[1]),
        .v_i        (v[1]),
        .adv_next_i (adv[3]),
        .adv_o      (adv[2]),
        .v_o        (v[2]),
        .acc_o      (acc[2])
    );

    tns_dec_group_stage #(.DW(DW), .W_A(TNS03_A), .W_B(TNS03_B), .W_C(TNS03_C)) u_stage3 (
        .clock      (clock),
        .rst        (rst),
        .grp_i      (rem2_q[8:6]),
        .acc_i      (acc[2]),
        .v_i        (v[2]),
        .adv_next_i (adv[4]),
        .adv_o      (adv[3]),
        .v_o        (v[3]),
        .acc_o      (acc[3])
    );

    tns_dec_group_stage #(.DW(DW), .W_A(TNS02_A), .W_B(TNS02_B), .W_C(TNS02_C)) u_stage4 (
        .clock      (clock),
        .rst        (rst),
        .grp_i      (rem3_q[5:3]),
        .acc_i      (acc[3]),
        .v_i        (v[3]),
        .adv_next_i (adv[5]),
        .adv_o      (adv[4]),
        .v_o        (v[4]),
        .acc_o      (acc[4])
    );

    // Group 1's third bit is codeword bit 0, which carries the unit weight.
    tns_dec_group_stage #(.DW(DW), .W_A(TNS01_A), .W_B(TNS01_B), .W_C(TNS01_C)) u_stage5 (
        .clock      (clock),
        .rst        (rst),
        .grp_i      (rem4_q),
        .acc_i      (acc[4]),
        .v_i        (v[4]),
        .adv_next_i (out_ready),
        .adv_o      (adv[5]),
        .v_o        (v[5]),
        .acc_o      (acc[5])
    );

    assign in_ready  = adv[1];
    assign data_out  = acc[5];
    assign out_valid = v[5];

endmodule

// File: tb/tb_tns_decoder_15_pipe.sv
// Bench for tns_decoder_15_pipe: reference model sums Fibonacci bit weights and
// a greedy encoder produces codewords for the round-trip scenario.
module tb_tns_decoder_15_pipe;

    logic        clock = 1'b0;
    logic        rst;
    logic [14:0] code_in;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] data_out;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    int wt [15];

    always #5 clock = ~clock;

    tns_decoder_15_pipe #(.GROUPS(5), .DW(11)) dut (
        .clock     (clock),
        .rst       (rst),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic int ref_decode(input logic [14:0] c);
        int s = 0;
        for (int i = 0; i < 15; i++) if (c[i]) s += wt[i];
        return s % 2048;
    endfunction

    function automatic logic [14:0] ref_encode(input int d);
        int          r = d;
        logic [14:0] c = '0;
        for (int i = 14; i >= 0; i--) begin
            if (r >= wt[i]) begin
                c[i] = 1'b1;
                r -= wt[i];
            end
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; code_in = '0;
        repeat (2) begin
            tick();
            checks++;
            if (data_out !== 11'd0 || out_valid !== 1'b0)
                $display("FAIL reset_state: data_out=%0d out_valid=%0b expected 0/0", data_out, out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        code_in = 15'h0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; code_in = 15'($urandom);
        for (int k = 1; k <= 8; k++) begin
            #1;
            checks++;
            if (out_valid !== (k == 5)) begin
                failures++;
                $display("FAIL reset_latency: cycle %0d out_valid=%0b expected %0b", k, out_valid, (k == 5));
            end
            if (k == 5 && data_out !== 11'd1) begin
                failures++;
                $display("FAIL reset_data: got %0d expected 1", data_out);
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        int exp_q[$];
        int sent = 0, got = 0, cyc = 0;
        bit started = 0;
        out_ready = 1'b1;
        while (got < 15 && cyc < 60) begin
            if (sent < 15) begin
                in_valid = 1'b1;
                code_in  = 15'(1) << (14 - sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL sweep_in_ready: got %0b expected 1", in_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(wt[14 - sent]);
                sent++;
            end
            checks++;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sweep_unexpected: got %0d expected no output", data_out);
                end else begin
                    int e = exp_q.pop_front();
                    if (data_out !== 11'(e)) begin
                        failures++;
                        $display("FAIL sweep_data: word %0d got %0d expected %0d", got, data_out, e);
                    end
                end
                got++;
                started = 1;
            end else if (started) begin
                failures++;
                $display("FAIL sweep_gap: out_valid=%0b expected 1 after %0d words", out_valid, got);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 15) begin
            failures++;
            $display("FAIL sweep_count: got %0d words expected 15", got);
        end
    endtask

    task automatic test_backpressure();
        int          exp_q[$];
        logic [14:0] words [7];
        int          sent = 0, got = 0, cyc = 0;
        bit          held = 0;
        logic [10:0] held_data = '0;
        for (int i = 0; i < 7; i++) words[i] = 15'($urandom);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (sent < 7);
            code_in  = (sent < 7) ? words[sent] : 15'($urandom);
            #1;
            checks++;
            if (in_ready !== (sent < 5)) begin
                failures++;
                $display("FAIL bp_in_ready: cycle %0d got %0b expected %0b", c, in_ready, (sent < 5));
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== held_data) begin
                    failures++;
                    $display("FAIL bp_stall_hold: data_out=%0d valid=%0b expected %0d/1", data_out, out_valid, held_data);
                end
            end else if (out_valid === 1'b1) begin
                held = 1;
                held_data = data_out;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_decode(words[sent]));
                sent++;
            end
            tick();
        end
        out_ready = 1'b1;
        while (got < 7 && cyc < 40) begin
            in_valid = (sent < 7);
            code_in  = (sent < 7) ? words[sent] : 15'($urandom);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_decode(words[sent]));
                sent++;
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_unexpected: got %0d expected no output", data_out);
                end else begin
                    int e = exp_q.pop_front();
                    if (data_out !== 11'(e)) begin
                        failures++;
                        $display("FAIL bp_data: word %0d got %0d expected %0d", got, data_out, e);
                    end
                end
                got++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 7 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got %0d words expected 7", got);
        end
    endtask

    task automatic test_bubble();
        int exp_q[$];
        int held = 0, c = 0;
        out_ready = 1'b0;
        while (held < 5 && c < 20) begin
            in_valid = (c % 2 == 0);
            code_in  = 15'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bubble_in_ready: %0d held got %0b expected 1", held, in_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_decode(code_in));
                held++;
            end
            tick();
            c++;
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bubble_full: in_ready got %0b expected 0", in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL bubble_packed: slot %0d out_valid=%0b expected 1", k, out_valid);
            end else begin
                int e = exp_q.pop_front();
                if (data_out !== 11'(e)) begin
                    failures++;
                    $display("FAIL bubble_data: slot %0d got %0d expected %0d", k, data_out, e);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bubble_drain: out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_roundtrip();
        int          exp_q[$];
        int          d_next = 0, got = 0, occ = 0, cyc = 0;
        bit          pending = 0, first = 1, prev_stall = 0;
        logic [10:0] prev_data = '0;
        while (got < 2048 && cyc < 15000) begin
            if (!pending) begin
                if (d_next < 2048 && $urandom_range(9) < 7) begin
                    in_valid = 1'b1;
                    code_in  = ref_encode(d_next);
                end else begin
                    in_valid = 1'b0;
                    code_in  = 15'($urandom);
                end
            end
            out_ready = ($urandom_range(9) < 8);
            #1;
            checks++;
            if (in_ready !== ((occ < 5) || out_ready)) begin
                failures++;
                $display("FAIL rt_in_ready: occ=%0d out_ready=%0b got %0b", occ, out_ready, in_ready);
            end
            if (!first) begin
                if (prev_stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || data_out !== prev_data) begin
                        failures++;
                        $display("FAIL rt_stall_hold: data_out=%0d valid=%0b expected %0d/1", data_out, out_valid, prev_data);
                    end
                end else if (out_valid !== 1'b1) begin
                    checks++;
                    if (data_out !== prev_data) begin
                        failures++;
                        $display("FAIL rt_idle_toggle: data_out=%0d expected %0d", data_out, prev_data);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(d_next);
                d_next++;
                occ++;
                pending = 0;
            end else begin
                pending = in_valid;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rt_unexpected: got %0d expected no output", data_out);
                end else begin
                    int e = exp_q.pop_front();
                    if (data_out !== 11'(e)) begin
                        failures++;
                        $display("FAIL rt_data: got %0d expected %0d", data_out, e);
                    end
                end
                got++;
                occ--;
            end
            prev_data  = data_out;
            prev_stall = out_valid && !out_ready;
            first      = 0;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 2048) begin
            failures++;
            $display("FAIL rt_count: got %0d words expected 2048", got);
        end
        repeat (8) tick();
    endtask

    task automatic test_midreset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            code_in  = 15'h4000 | 15'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_fill: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
            end
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; code_in = 15'($urandom);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 11'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_cleared: valid=%0b data=%0d in_ready=%0b expected 0/0/1", out_valid, data_out, in_ready);
        end
        code_in = 15'h0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; code_in = 15'($urandom);
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++;
            if (out_valid !== (k == 5)) begin
                failures++;
                $display("FAIL mid_latency: cycle %0d out_valid=%0b expected %0b", k, out_valid, (k == 5));
            end
            if (k == 5 && data_out !== 11'd1) begin
                failures++;
                $display("FAIL mid_data: got %0d expected 1", data_out);
            end
            tick();
        end
    endtask

    initial begin
        wt[0] = 1;
        wt[1] = 2;
        for (int i = 2; i < 15; i++) wt[i] = wt[i-1] + wt[i-2];
        test_reset();
        test_sweep();
        test_backpressure();
        test_bubble();
        test_roundtrip();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
